// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA/CPU memory arbiter.
package vga_pkg;

  // Arbiter state: names the grant made in the previous cycle.
  typedef enum logic [2:0] {
    IDLE,
    VGA,
    CPU_RD,
    CPU_WR,
    TURN
  } arb_state_t;

  // Owner of an in-flight read, carried down the read-tag pipe.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VGA,
    OWN_CPU
  } owner_t;

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 3;
  localparam int WR_TURN_MIN = 0;
  localparam int WR_TURN_MAX = 2;
  localparam int TURN_W      = 2;

endpackage

// File: rtl/vga_rd_tag_pipe.sv
// Owner-tag shift register: aligns read ownership with the memory's read latency.
module vga_rd_tag_pipe import vga_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  owner_t tag_in,
  output owner_t tag_out
);

  owner_t tag_pipe [DEPTH];

  // Shift one tag per cycle; reset drops every in-flight read.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tag_pipe[i] <= OWN_NONE;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[DEPTH-1];

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter: VGA fetches have strict priority, CPU takes spare slots.
// A CPU write is followed by WR_TURN dead cycles; VGA requests denied are counted.
// Optional macro VGA_BLANK_ONLY_CPU_EN restricts CPU grants to blanking (bright==0).
module vga_mem_arbiter import vga_pkg::*; #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RD_LAT  = 1,
  parameter int WR_TURN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              bright,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              vga_miss,
  output logic [15:0]       miss_count
);

  arb_state_t        state, state_nxt;
  logic [TURN_W-1:0] turn_cnt, turn_cnt_nxt;
  logic              cpu_elig;
  logic              grant_vga, grant_cpu;
  owner_t            tag_in, tag_out;
  logic [DATA_W-1:0] vga_rdata_q, cpu_rdata_q;

`ifdef VGA_BLANK_ONLY_CPU_EN
  assign cpu_elig = !bright;
`else
  logic unused_bright;
  assign unused_bright = bright;
  assign cpu_elig = 1'b1;
`endif

  // Next-state and grant selection; grants are suppressed while reset is asserted.
  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    grant_vga    = 1'b0;
    grant_cpu    = 1'b0;
    if (state == TURN && turn_cnt != '0) begin
      turn_cnt_nxt = turn_cnt - 1'b1;
      state_nxt    = (turn_cnt == TURN_W'(1)) ? IDLE : TURN;
    end else if (vga_req) begin
      grant_vga = reset_n;
      state_nxt = VGA;
    end else if (cpu_req && cpu_elig) begin
      grant_cpu = reset_n;
      if (!cpu_we) begin
        state_nxt = CPU_RD;
      end else if (WR_TURN > 0) begin
        // Write goes straight to TURN so the dead cycles start right after it.
        state_nxt    = TURN;
        turn_cnt_nxt = TURN_W'(WR_TURN);
      end else begin
        state_nxt = CPU_WR;
      end
    end else begin
      state_nxt = IDLE;
    end
  end

  assign vga_ack   = grant_vga;
  assign cpu_ack   = grant_cpu;
  assign mem_en    = grant_vga | grant_cpu;
  assign mem_we    = grant_cpu & cpu_we;
  assign mem_addr  = grant_cpu ? cpu_addr : vga_addr;
  assign mem_wdata = (grant_cpu && cpu_we) ? cpu_wdata : '0;
  assign vga_miss  = reset_n & vga_req & !grant_vga;

  assign tag_in = grant_vga                ? OWN_VGA :
                  (grant_cpu && !cpu_we)   ? OWN_CPU : OWN_NONE;

  vga_rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Route returning read data to its owner; rdata holds between returns.
  assign vga_rvalid = reset_n && (tag_out == OWN_VGA);
  assign cpu_rvalid = reset_n && (tag_out == OWN_CPU);
  assign vga_rdata  = vga_rvalid ? mem_rdata : vga_rdata_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;

  // State, turnaround counter, miss counter and held read data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      turn_cnt    <= '0;
      miss_count  <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      if (vga_miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      if (vga_rvalid) vga_rdata_q <= mem_rdata;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: RD_LAT=1 instance with a memory model,
// plus an RD_LAT=3 instance for latency and reset-drop behaviour.
module tb_vga_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset_n, bright, vga_req, cpu_req, cpu_we;
  logic [AW-1:0] vga_addr, cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, vga_rdata, cpu_rdata, mem_wdata, mem_rdata;
  logic          vga_ack, vga_rvalid, cpu_ack, cpu_rvalid, mem_en, mem_we, vga_miss;
  logic [15:0]   miss_count;

  logic          rst3_n, cpu_req3;
  logic [AW-1:0] cpu_addr3, mem_addr3;
  logic [DW-1:0] vga_rdata3, cpu_rdata3, mem_wdata3, mem_rdata3;
  logic          vga_ack3, vga_rvalid3, cpu_ack3, cpu_rvalid3, mem_en3, mem_we3, vga_miss3;
  logic [15:0]   miss_count3;
  logic          zero1;
  logic [AW-1:0] zero_a;
  logic [DW-1:0] zero_d;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_vga [$];
  logic [DW-1:0] exp_cpu [$];
  logic [DW-1:0] exp_cpu3 [$];
  logic [DW-1:0] mem [1024];

  always #10 clock = ~clock;

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .WR_TURN(1)) dut (
    .clock(clock), .reset_n(reset_n), .bright(bright),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .vga_miss(vga_miss), .miss_count(miss_count)
  );

  vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .WR_TURN(1)) dut3 (
    .clock(clock), .reset_n(rst3_n), .bright(zero1),
    .vga_req(zero1), .vga_addr(zero_a), .vga_ack(vga_ack3),
    .vga_rdata(vga_rdata3), .vga_rvalid(vga_rvalid3),
    .cpu_req(cpu_req3), .cpu_we(zero1), .cpu_addr(cpu_addr3), .cpu_wdata(zero_d),
    .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3), .cpu_rvalid(cpu_rvalid3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .vga_miss(vga_miss3), .miss_count(miss_count3)
  );

  // Behavioural single-port RAM with one-cycle registered read for the main DUT.
  always @(posedge clock) begin
    if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every rvalid pops the oldest expected read for that owner.
  always @(negedge clock) begin
    if (vga_rvalid) begin
      if (exp_vga.size() == 0) check("vga_rvalid_unexpected", 32'(vga_rdata), 32'hFFFF_FFFF);
      else check("vga_rdata", 32'(vga_rdata), 32'(exp_vga.pop_front()));
    end
    if (cpu_rvalid) begin
      if (exp_cpu.size() == 0) check("cpu_rvalid_unexpected", 32'(cpu_rdata), 32'hFFFF_FFFF);
      else check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu.pop_front()));
    end
    if (cpu_rvalid3) begin
      if (exp_cpu3.size() == 0) check("cpu_rvalid3_unexpected", 32'(cpu_rdata3), 32'hFFFF_FFFF);
      else check("cpu_rdata3", 32'(cpu_rdata3), 32'(exp_cpu3.pop_front()));
    end
    if (vga_rvalid3) check("vga_rvalid3_unexpected", 32'(vga_rdata3), 32'hFFFF_FFFF);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = {i[7:0], ~i[7:0]};
    zero1 = 1'b0; zero_a = '0; zero_d = '0; mem_rdata3 = 16'hBEEF;
    // Reset held with every request asserted.
    reset_n = 1'b0; rst3_n = 1'b0; bright = 1'b0;
    vga_req = 1'b1; vga_addr = 16'h0010;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0003; cpu_wdata = 16'h1234;
    cpu_req3 = 1'b1; cpu_addr3 = 16'h0040;
    step(); step();
    @(negedge clock);
    check("rst_vga_ack", 32'(vga_ack), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_rvalids", 32'({vga_rvalid, cpu_rvalid}), 0);
    check("rst_vga_miss", 32'(vga_miss), 0);
    check("rst_miss_count", 32'(miss_count), 0);
    check("rst3_acks", 32'({vga_ack3, cpu_ack3, mem_en3, mem_we3, vga_miss3}), 0);
    check("rst3_miss_count", 32'(miss_count3), 0);

    step();
    reset_n = 1'b1; rst3_n = 1'b1;
    vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_req3 = 1'b0;
    @(negedge clock);
    check("idle_mem_en", 32'(mem_en), 0);
    check("idle_mem_wdata", 32'(mem_wdata), 0);

    // VGA back-to-back fetches at 0x0010.
    for (int i = 0; i < 4; i++) begin
      step();
      vga_req = 1'b1; vga_addr = 16'h0010;
      @(negedge clock);
      check("vga_ack_b2b", 32'(vga_ack), 1);
      check("vga_mem_addr", 32'(mem_addr), 32'h0010);
      check("vga_mem_we", 32'(mem_we), 0);
      exp_vga.push_back(16'h10EF);
    end
    step();
    vga_req = 1'b0;
    @(negedge clock);
    check("vga_ack_drop", 32'(vga_ack), 0);
    check("vga_rvalid_last", 32'(vga_rvalid), 1);
    step();
    @(negedge clock);
    check("vga_rvalid_end", 32'(vga_rvalid), 0);
    check("vga_rdata_hold", 32'(vga_rdata), 32'h10EF);

    // Collision: VGA wins, CPU read follows.
    step();
    vga_req = 1'b1; vga_addr = 16'h0020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    @(negedge clock);
    check("coll_vga_ack", 32'(vga_ack), 1);
    check("coll_cpu_wait", 32'(cpu_ack), 0);
    check("coll_mem_addr", 32'(mem_addr), 32'h0020);
    exp_vga.push_back(16'h20DF);
    step();
    vga_req = 1'b0;
    @(negedge clock);
    check("coll_cpu_ack", 32'(cpu_ack), 1);
    check("coll_cpu_addr", 32'(mem_addr), 32'h0200);
    exp_cpu.push_back(16'h00FF);
    step();
    cpu_req = 1'b0;
    @(negedge clock);
    check("coll_cpu_rvalid", 32'(cpu_rvalid), 1);
    check("coll_vga_rvalid", 32'(vga_rvalid), 0);

    // Write turnaround: one dead cycle, VGA miss counted.
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0005; cpu_wdata = 16'h00AB;
    @(negedge clock);
    check("wr_cpu_ack", 32'(cpu_ack), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h00AB);
    check("wr_mem_addr", 32'(mem_addr), 32'h0005);
    check("wr_miss_count0", 32'(miss_count), 0);
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    vga_req = 1'b1; vga_addr = 16'h0030;
    @(negedge clock);
    check("turn_vga_ack", 32'(vga_ack), 0);
    check("turn_mem_en", 32'(mem_en), 0);
    check("turn_vga_miss", 32'(vga_miss), 1);
    step();
    @(negedge clock);
    check("post_turn_vga_ack", 32'(vga_ack), 1);
    check("post_turn_vga_miss", 32'(vga_miss), 0);
    check("miss_count1", 32'(miss_count), 1);
    exp_vga.push_back(16'h30CF);
    step();
    vga_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005; cpu_wdata = 16'h5555;
    @(negedge clock);
    check("rdback_cpu_ack", 32'(cpu_ack), 1);
    check("rd_mem_wdata_zero", 32'(mem_wdata), 0);
    exp_cpu.push_back(16'h00AB);
    step();
    cpu_req = 1'b0;

    // CPU eligibility versus bright.
`ifdef VGA_BLANK_ONLY_CPU_EN
    for (int i = 0; i < 10; i++) begin
      step();
      bright = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      @(negedge clock);
      check("bright_cpu_wait", 32'(cpu_ack), 0);
    end
    step();
    bright = 1'b0;
    @(negedge clock);
    check("blank_cpu_ack", 32'(cpu_ack), 1);
    exp_cpu.push_back(16'h10EF);
`else
    step();
    bright = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    @(negedge clock);
    check("bright_ignored_ack", 32'(cpu_ack), 1);
    exp_cpu.push_back(16'h10EF);
`endif
    step();
    cpu_req = 1'b0; bright = 1'b0;

    // RD_LAT=3: normal read returns on the third cycle after the grant.
    step();
    cpu_req3 = 1'b1; cpu_addr3 = 16'h0040;
    @(negedge clock);
    check("lat3_cpu_ack", 32'(cpu_ack3), 1);
    check("lat3_mem_addr", 32'(mem_addr3), 32'h0040);
    exp_cpu3.push_back(16'hBEEF);
    step();
    cpu_req3 = 1'b0;
    @(negedge clock);
    check("lat3_rvalid_c1", 32'(cpu_rvalid3), 0);
    step();
    @(negedge clock);
    check("lat3_rvalid_c2", 32'(cpu_rvalid3), 0);
    step();
    @(negedge clock);
    check("lat3_rvalid_c3", 32'(cpu_rvalid3), 1);

    // RD_LAT=3: reset one cycle after the grant drops the read.
    step();
    cpu_req3 = 1'b1;
    @(negedge clock);
    check("drop_cpu_ack", 32'(cpu_ack3), 1);
    step();
    cpu_req3 = 1'b0; rst3_n = 1'b0;
    @(negedge clock);
    check("drop_rst_en", 32'(mem_en3), 0);
    step();
    rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("drop_no_rvalid", 32'(cpu_rvalid3), 0);
      step();
    end

    repeat (3) step();
    check("vga_queue_drained", 32'(exp_vga.size()), 0);
    check("cpu_queue_drained", 32'(exp_cpu.size()), 0);
    check("cpu3_queue_drained", 32'(exp_cpu3.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
